retire_trace_fifo: RTL and testbench

//   Downstream consumer of the multi-cycle CPU's retirement outputs (pc, inst, result).

---
 rtl/retire_trace_pkg.sv | 21 ++
 rtl/retire_trace_mem.sv | 33 +++
 rtl/retire_trace_fifo.sv | 158 +++++++++++++++
 tb/tb_retire_trace_fifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : retire_trace_pkg
//  Description : Shared widths and the trace record layout for the
//                retirement trace FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package retire_trace_pkg;

    localparam int TRACE_W  = 96;   // pc + inst + result
    localparam int TSTAMP_W = 32;   // cycle stamp width (optional feature)
    localparam int DROP_W   = 16;   // saturating drop counter width

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] result;
    } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/retire_trace_mem.sv
`default_nettype none
// ============================================================================
//  Module      : retire_trace_mem
//  Description : DEPTH x DATA_W trace storage, one synchronous write port and
//                one asynchronous read port. Contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module retire_trace_mem #(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write the incoming record at the tail slot.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/retire_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : retire_trace_fifo
//  Description : Captures one {pc, inst, result} record per retired
//                instruction into a circular buffer and drains it over a
//                valid/ready port. Records arriving while full (and not
//                popped that cycle) are dropped and counted.
//                Optional macro RETIRE_TSTAMP_EN adds a free-running cycle
//                stamp stored with every entry and the out_tstamp port.
//  Revision    : 1.0  initial release
// ============================================================================
module retire_trace_fifo
    import retire_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              resetn,        // active-high async reset despite the name
    input  logic              clear,
    input  logic              retire_valid,
    input  logic [31:0]       retire_pc,
    input  logic [31:0]       retire_inst,
    input  logic [31:0]       retire_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_result,
`ifdef RETIRE_TSTAMP_EN
    output logic [31:0]       out_tstamp,
`endif
    output logic [AW:0]       count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

`ifdef RETIRE_TSTAMP_EN
    localparam int MEM_W = TRACE_W + TSTAMP_W;
`else
    localparam int MEM_W = TRACE_W;
`endif
    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_out_valid;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_wr_en;
    logic [AW:0]       w_count_nxt;
    trace_entry_t      w_wr_entry;
    trace_entry_t      w_head;
    logic [MEM_W-1:0]  w_wr_data;
    logic [MEM_W-1:0]  w_rd_data;

    // A push is allowed when there is room, or when a pop frees the slot in
    // the same cycle. Pop only sees the registered valid, so an empty FIFO
    // never bypasses the incoming record to the output.
    assign w_pop   = r_out_valid & out_ready;
    assign w_push  = retire_valid & ((r_count != c_full) | w_pop);
    assign w_drop  = retire_valid & ~w_push;
    assign w_wr_en = w_push & ~clear;

    assign w_wr_entry = '{pc: retire_pc, inst: retire_inst, result: retire_result};

`ifdef RETIRE_TSTAMP_EN
    logic [TSTAMP_W-1:0] r_tstamp;

    // Free-running cycle counter; only reset clears it, clear does not.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_tstamp <= '0;
        end else begin
            r_tstamp <= r_tstamp + 1'b1;
        end
    end

    assign w_wr_data  = {r_tstamp, w_wr_entry};
    assign out_tstamp = r_out_valid ? w_rd_data[MEM_W-1:TRACE_W] : '0;
`else
    assign w_wr_data  = w_wr_entry;
`endif

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer, occupancy and overflow bookkeeping; clear beats push/pop.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

    retire_trace_mem #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (MEM_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Head fields are forced to zero while empty so stale storage never leaks.
    assign w_head     = trace_entry_t'(w_rd_data[TRACE_W-1:0]);
    assign out_valid  = r_out_valid;
    assign out_pc     = r_out_valid ? w_head.pc     : '0;
    assign out_inst   = r_out_valid ? w_head.inst   : '0;
    assign out_result = r_out_valid ? w_head.result : '0;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_retire_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_retire_trace_fifo
//  Description : Directed self-checking bench for retire_trace_fifo.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_retire_trace_fifo;

    logic        clk;
    logic        resetn;
    logic        clear;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_inst;
    logic [31:0] retire_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_result;
`ifdef RETIRE_TSTAMP_EN
    logic [31:0] out_tstamp;
`endif
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    retire_trace_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .clear         (clear),
        .retire_valid  (retire_valid),
        .retire_pc     (retire_pc),
        .retire_inst   (retire_inst),
        .retire_result (retire_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_result    (out_result),
`ifdef RETIRE_TSTAMP_EN
        .out_tstamp    (out_tstamp),
`endif
        .count         (count),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] res);
        retire_valid  = 1'b1;
        retire_pc     = pc;
        retire_inst   = inst;
        retire_result = res;
    endtask

`ifdef RETIRE_TSTAMP_EN
    logic [31:0] ts0;
    logic [31:0] ts1;
    logic [31:0] ts2;
`endif

    initial begin
        resetn = 1'b1; clear = 1'b0; retire_valid = 1'b0; out_ready = 1'b0;
        retire_pc = '0; retire_inst = '0; retire_result = '0;
        tick(); tick();
        resetn = 1'b0;
        tick();

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_drop",  32'(drop_cnt), 32'd0);
        chk("rst_pc",    out_pc, 32'd0);

        // Ready while empty has no effect
        out_ready = 1'b1;
        tick();
        chk("empty_ready_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Single record, visible the next cycle
        strobe(32'h0000_0004, 32'h2008_0005, 32'd5);
        tick();
        retire_valid = 1'b0;
        chk("one_valid",  32'(out_valid), 32'd1);
        chk("one_pc",     out_pc, 32'h0000_0004);
        chk("one_inst",   out_inst, 32'h2008_0005);
        chk("one_result", out_result, 32'd5);
        chk("one_count",  32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("one_pop_count", 32'(count), 32'd0);
        chk("one_pop_valid", 32'(out_valid), 32'd0);
        chk("one_pop_pc",    out_pc, 32'd0);

        // Fill with 9 strobes, ready low: the ninth is dropped
        for (int i = 0; i < 9; i++) begin
            strobe(32'h100 + 32'(i) * 4, 32'hA000_0000 + 32'(i), 32'(i) * 3);
            tick();
        end
        retire_valid = 1'b0;
        chk("full_count", 32'(count), 32'd8);
        chk("full_ovf",   32'(overflow), 32'd1);
        chk("full_drop",  32'(drop_cnt), 32'd1);
        chk("full_head",  out_pc, 32'h100);

        // Full with push and pop together: accepted, no drop
        strobe(32'h200, 32'hB000_0000, 32'h77);
        out_ready = 1'b1;
        tick();
        retire_valid = 1'b0;
        chk("fpp_count", 32'(count), 32'd8);
        chk("fpp_drop",  32'(drop_cnt), 32'd1);

        // Drain: 0x104..0x11C, then the late record 0x200
        for (int i = 1; i < 8; i++) begin
            chk("drain_pc",   out_pc, 32'h100 + 32'(i) * 4);
            chk("drain_inst", out_inst, 32'hA000_0000 + 32'(i));
            tick();
        end
        chk("drain_tail_pc",  out_pc, 32'h200);
        chk("drain_tail_res", out_result, 32'h77);
        tick();
        chk("drain_empty", 32'(count), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b0;

        // 20 push/pop pairs with ready held high: pointers wrap
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            strobe(32'h1000 + 32'(i) * 4, 32'(i), 32'(i));
            tick();
            chk("stream_pc",    out_pc, 32'h1000 + 32'(i) * 4);
            chk("stream_count", 32'(count), 32'd1);
        end
        retire_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("stream_end_count", 32'(count), 32'd0);
        chk("stream_drop",      32'(drop_cnt), 32'd1);

        // clear with a strobe while holding 5 entries
        for (int i = 0; i < 5; i++) begin
            strobe(32'h3000 + 32'(i) * 4, 32'd0, 32'd0);
            tick();
        end
        chk("pre_clear_count", 32'(count), 32'd5);
        strobe(32'h4000, 32'd1, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        retire_valid = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_ovf",   32'(overflow), 32'd0);
        chk("clr_drop",  32'(drop_cnt), 32'd0);
        tick();
        chk("clr_discard_count", 32'(count), 32'd0);
        chk("clr_discard_pc",    out_pc, 32'd0);

`ifdef RETIRE_TSTAMP_EN
        // Strobes three cycles apart give stamp deltas of 3
        resetn = 1'b1; #1; resetn = 1'b0;
        tick();
        strobe(32'h10, 32'd0, 32'd0); tick(); retire_valid = 1'b0;
        tick(); tick();
        strobe(32'h14, 32'd0, 32'd0); tick(); retire_valid = 1'b0;
        tick(); tick();
        strobe(32'h18, 32'd0, 32'd0); tick(); retire_valid = 1'b0;
        ts0 = out_tstamp;
        out_ready = 1'b1;
        tick(); ts1 = out_tstamp;
        tick(); ts2 = out_tstamp;
        tick();
        out_ready = 1'b0;
        chk("ts_delta1", ts1 - ts0, 32'd3);
        chk("ts_delta2", ts2 - ts1, 32'd3);
`endif

        // Async reset pulse in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            strobe(32'h5000 + 32'(i) * 4, 32'd9, 32'd9);
            tick();
        end
        retire_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mid_drain_count", 32'(count), 32'd2);
        chk("mid_drain_pc",    out_pc, 32'h5004);
        #2 resetn = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_pc",    out_pc, 32'd0);
        chk("arst_inst",  out_inst, 32'd0);
`ifdef RETIRE_TSTAMP_EN
        chk("arst_tstamp", out_tstamp, 32'd0);
`endif
        #1 resetn = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("post_arst_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
